img_fetch_ctrl: RTL and testbench
=================================

# img_fetch_ctrl

Sequencer between the parallel NOR flash and the frame-buffer writer in the picture-frame datapath. It selects one of several images stored back-to-back in flash and walks its byte addresses with programmable wait states. It packs byte pairs into 16-bit pixels and streams them out through a valid/ready handshake. Image selection comes from the IR command decoder: reload, next, previous and first.

## Interface
- FLASH_AW, 23: flash byte-address width.
- IMG_BYTES, 153600: bytes per image (320x240x16bpp); must be even and ≥ 2.
- NUM_IMG, 8: images stored in flash, starting at address 0.
- FLASH_WAIT, 7: extra cycles each flash address is held before data is sampled.
- SLIDE_CYCLES, 250000000: slideshow interval; used only with IMG_SLIDESHOW_EN.
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  IR command strobe.
- cmd_code  in  2  00 reload, 01 next, 10 prev, 11 first.
- cmd_ready  out  1  high only in IDLE.
- fl_addr  out  FLASH_AW  flash byte address.
- fl_oe  out  1  read enable, active-high.
- fl_data  in  8  flash read data.
- px_data  out  16  packed pixel.
- px_addr  out  FLASH_AW-1  word index within current image.
- px_valid  out  1  pixel available.
- px_ready  in  1  frame-buffer writer accepts.
- img_idx  out  clog2(NUM_IMG)  current image.
- busy  out  1  fetch in progress (state ≠ IDLE).
- frame_done  out  1  one-cycle pulse after last pixel accepted.

## Operation
- States: IDLE, SETUP, RD_LO, RD_HI, PUSH.
- Reset: all outputs 0, img_idx=0, next state SETUP. Image 0 auto-loads after every reset, including a reset asserted mid-fetch, which aborts the fetch with no further px_valid.
- IDLE: cmd_ready=1. cmd_valid is accepted in the same cycle and updates img_idx:
  - next: (idx+1) mod NUM_IMG; NUM_IMG-1 wraps to 0.
  - prev: idx=0 wraps to NUM_IMG-1.
  - first: 0. reload: unchanged.
  - Then go to SETUP. cmd_valid outside IDLE is ignored, not queued.
- SETUP (1 cycle): base = img_idx*IMG_BYTES (FLASH_AW bits, accumulated in a register); byte offset=0.
- RD_LO / RD_HI: fl_addr=base+offset, fl_oe=1, wait counter counts 0..FLASH_WAIT.
  - fl_data is sampled on the cycle the counter reaches FLASH_WAIT.
  - RD_LO writes px_data[7:0] (even offset); RD_HI writes px_data[15:8] (odd offset). offset increments after each sample.
- PUSH: px_valid=1; px_data and px_addr=offset/2-1 are held stable until px_ready.
  - On handshake, if offset==IMG_BYTES: pulse frame_done and go to IDLE. Otherwise go to RD_LO.
- fl_oe=0 outside RD_LO/RD_HI. fl_addr holds its last value.

## Timing
- Each byte occupies FLASH_WAIT+1 cycles. With px_ready tied high, one word takes 2(FLASH_WAIT+1)+1 cycles.
- Accepted command to first fl_oe: 2 cycles (IDLE→SETUP→RD_LO).
- frame_done is asserted in the cycle after the final handshake, concurrent with the return to IDLE. cmd_ready=1 in that same cycle.
- px_valid never drops without a handshake. A px_ready stall extends PUSH indefinitely and does not affect flash timing.
- Register offset and base to FLASH_AW bits. With the default parameters the last address is 8*153600-1 = 1228799, which fits in 23 bits.

## Configuration
- IMG_SLIDESHOW_EN defined: a counter runs in IDLE. After SLIDE_CYCLES idle cycles, an internal "next" command fires, identical to an IR next.
  - Any accepted command, and any exit from IDLE, clears the counter.
  - IR cmd_valid has priority over the timer in the same cycle.
- Undefined: no timer logic. The block stays in IDLE until cmd_valid arrives.

## Structure
- Package img_pkg: cmd_code constants (CMD_RELOAD, CMD_NEXT, CMD_PREV, CMD_FIRST), state enum type, FLASH_AW default.
- Sub-module flash_byte_rd:
  - Handles wait-state counting and fl_data sampling.
  - Inputs: start, addr. Outputs: fl_addr, fl_oe, byte_valid (1-cycle), byte.
  - Instantiated once; the top FSM sequences it twice per pixel.

## Test plan
Bench parameters: IMG_BYTES=8, NUM_IMG=4, FLASH_WAIT=2, flash model data = address[7:0].
- Reset, px_ready=1:
  - 4 pixels 0x0100, 0x0302, 0x0504, 0x0706 at px_addr 0..3.
  - 7 cycles per word.
  - frame_done pulses once; busy drops.
- IDLE, cmd next ×3: img_idx 1, 2, 3; the third fetch's first pixel is 0x1918.
  - Another next wraps to 0.
  - prev from 0 goes to 3.
- cmd_valid during busy: ignored. img_idx is unchanged and cmd_ready=0 throughout the fetch.
- px_ready held low 10 cycles during a PUSH:
  - px_data and px_addr stable, fl_oe=0.
  - The next byte read starts the cycle after the handshake.
- Reset asserted at pixel 2 of image 2:
  - px_valid=0 the next cycle.
  - Fetch restarts at fl_addr 0, img_idx=0.
- With IMG_SLIDESHOW_EN and SLIDE_CYCLES=20: 20 idle cycles after frame_done, img_idx advances automatically.
  - An IR first command at idle cycle 15 resets the timer.

Source files
------------

// File: rtl/img_pkg.sv
// Shared types and constants for the image fetch sequencer.
package img_pkg;

  // Default flash byte-address width.
  localparam int unsigned FLASH_AW_DEF = 23;

  // IR command encodings.
  localparam logic [1:0] CMD_RELOAD = 2'b00;
  localparam logic [1:0] CMD_NEXT   = 2'b01;
  localparam logic [1:0] CMD_PREV   = 2'b10;
  localparam logic [1:0] CMD_FIRST  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StRdLo,
    StRdHi,
    StPush
  } state_e;

endpackage

// File: rtl/flash_byte_rd.sv
// Single-byte flash reader: holds the address with fl_oe asserted for FLASH_WAIT+1 cycles and
// flags the final cycle, in which fl_data is taken.
// start is held high for as long as reads are wanted; back-to-back bytes need no gap cycle.
module flash_byte_rd #(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned FLASH_WAIT = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        fl_data,
  output logic [ADDR_W-1:0] fl_addr,
  output logic              fl_oe,
  output logic              byte_valid,
  output logic [7:0]        rd_byte
);

  localparam int unsigned CntW = (FLASH_WAIT > 0) ? $clog2(FLASH_WAIT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FLASH_WAIT);

  logic [CntW-1:0]   cnt_q;
  logic [ADDR_W-1:0] addr_q;

  // Wait-state counter: runs 0..FLASH_WAIT while reading, rests at 0 otherwise.
  always_ff @(posedge clock) begin
    if (reset || !start || cnt_q == CntLast) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Remember the last driven address so fl_addr stays put between reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
    end else if (start) begin
      addr_q <= addr;
    end
  end

  assign fl_oe      = start;
  assign fl_addr    = start ? addr : addr_q;
  assign byte_valid = start && (cnt_q == CntLast);
  assign rd_byte    = fl_data;

endmodule

// File: rtl/img_fetch_ctrl.sv
// Image fetch sequencer: picks an image from flash, reads it byte by byte and streams 16-bit
// pixels over a valid/ready handshake.
// Optional feature: define IMG_SLIDESHOW_EN to auto-advance after SLIDE_CYCLES idle cycles.
module img_fetch_ctrl
  import img_pkg::*;
#(
  parameter int unsigned FLASH_AW     = FLASH_AW_DEF,
  parameter int unsigned IMG_BYTES    = 153600,
  parameter int unsigned NUM_IMG      = 8,
  parameter int unsigned FLASH_WAIT   = 7,
  parameter int unsigned SLIDE_CYCLES = 250000000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cmd_valid,
  input  logic [1:0]                 cmd_code,
  output logic                       cmd_ready,
  output logic [FLASH_AW-1:0]        fl_addr,
  output logic                       fl_oe,
  input  logic [7:0]                 fl_data,
  output logic [15:0]                px_data,
  output logic [FLASH_AW-2:0]        px_addr,
  output logic                       px_valid,
  input  logic                       px_ready,
  output logic [$clog2(NUM_IMG)-1:0] img_idx,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int unsigned IdxW = $clog2(NUM_IMG);
  localparam logic [IdxW-1:0]     IdxLast  = IdxW'(NUM_IMG - 1);
  localparam logic [FLASH_AW-1:0] ImgStep  = FLASH_AW'(IMG_BYTES);
  localparam logic [FLASH_AW-1:0] LastBase = FLASH_AW'((NUM_IMG - 1) * IMG_BYTES);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [FLASH_AW-1:0] base_q, base_d;
  logic [FLASH_AW-1:0] offset_q, offset_d;
  logic [15:0]         px_data_q, px_data_d;
  logic [FLASH_AW-2:0] px_addr_q, px_addr_d;
  logic                frame_done_q, frame_done_d;

  logic                rd_start;
  logic [FLASH_AW-1:0] rd_addr;
  logic                byte_valid;
  logic [7:0]          rd_byte;
  logic [1:0]          cmd_sel;
  logic                slide_fire;

  assign rd_addr = base_q + offset_q;

  flash_byte_rd #(
    .ADDR_W     (FLASH_AW),
    .FLASH_WAIT (FLASH_WAIT)
  ) u_rd (
    .clock      (clock),
    .reset      (reset),
    .start      (rd_start),
    .addr       (rd_addr),
    .fl_data    (fl_data),
    .fl_addr    (fl_addr),
    .fl_oe      (fl_oe),
    .byte_valid (byte_valid),
    .rd_byte    (rd_byte)
  );

`ifdef IMG_SLIDESHOW_EN
  localparam int unsigned SlideW = $clog2(SLIDE_CYCLES + 1);
  localparam logic [SlideW-1:0] SlideLast = SlideW'(SLIDE_CYCLES - 1);

  logic [SlideW-1:0] slide_q;

  assign slide_fire = (state_q == StIdle) && (slide_q == SlideLast);

  // Idle-time counter; any accepted command or exit from IDLE restarts it.
  always_ff @(posedge clock) begin
    if (reset || state_q != StIdle || cmd_valid || slide_fire) begin
      slide_q <= '0;
    end else begin
      slide_q <= slide_q + SlideW'(1);
    end
  end
`else
  logic [31:0] unused_slide_cycles;
  assign unused_slide_cycles = SLIDE_CYCLES;
  assign slide_fire = 1'b0;
`endif

  // State and datapath registers; reset restarts the fetch of image 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StSetup;
      idx_q        <= '0;
      base_q       <= '0;
      offset_q     <= '0;
      px_data_q    <= '0;
      px_addr_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      base_q       <= base_d;
      offset_q     <= offset_d;
      px_data_q    <= px_data_d;
      px_addr_q    <= px_addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic: command decode, byte sequencing and pixel handoff.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    base_d       = base_q;
    offset_d     = offset_q;
    px_data_d    = px_data_q;
    px_addr_d    = px_addr_q;
    frame_done_d = 1'b0;
    rd_start     = 1'b0;
    cmd_sel      = cmd_valid ? cmd_code : CMD_NEXT;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid || slide_fire) begin
          // Image base tracks the index incrementally, avoiding a multiplier.
          unique case (cmd_sel)
            CMD_NEXT: begin
              if (idx_q == IdxLast) begin
                idx_d  = '0;
                base_d = '0;
              end else begin
                idx_d  = idx_q + IdxW'(1);
                base_d = base_q + ImgStep;
              end
            end
            CMD_PREV: begin
              if (idx_q == '0) begin
                idx_d  = IdxLast;
                base_d = LastBase;
              end else begin
                idx_d  = idx_q - IdxW'(1);
                base_d = base_q - ImgStep;
              end
            end
            CMD_FIRST: begin
              idx_d  = '0;
              base_d = '0;
            end
            CMD_RELOAD: begin
            end
          endcase
          state_d = StSetup;
        end
      end
      StSetup: begin
        offset_d = '0;
        state_d  = StRdLo;
      end
      StRdLo: begin
        rd_start = 1'b1;
        if (byte_valid) begin
          px_data_d[7:0] = rd_byte;
          offset_d       = offset_q + FLASH_AW'(1);
          state_d        = StRdHi;
        end
      end
      StRdHi: begin
        rd_start = 1'b1;
        if (byte_valid) begin
          px_data_d[15:8] = rd_byte;
          // Offset is odd here, so dropping bit 0 yields this pixel's word index.
          px_addr_d       = offset_q[FLASH_AW-1:1];
          offset_d        = offset_q + FLASH_AW'(1);
          state_d         = StPush;
        end
      end
      StPush: begin
        if (px_ready) begin
          if (offset_q == ImgStep) begin
            frame_done_d = 1'b1;
            state_d      = StIdle;
          end else begin
            state_d = StRdLo;
          end
        end
      end
      default: state_d = StSetup;
    endcase
  end

  assign cmd_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign px_valid   = (state_q == StPush);
  assign px_data    = px_data_q;
  assign px_addr    = px_addr_q;
  assign img_idx    = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_img_fetch_ctrl.sv
// Self-checking bench for img_fetch_ctrl: small image geometry, flash returns address[7:0].
module tb_img_fetch_ctrl;
  import img_pkg::*;

  localparam int unsigned AW       = 23;
  localparam int unsigned NB       = 8;
  localparam int unsigned NI       = 4;
  localparam int unsigned FW       = 2;
  localparam int unsigned NW       = NB / 2;
  localparam int unsigned WORD_CYC = 2 * (FW + 1) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_code = 2'b00;
  logic          px_ready = 1'b1;
  logic          cmd_ready;
  logic [AW-1:0] fl_addr;
  logic          fl_oe;
  logic [7:0]    fl_data;
  logic [15:0]   px_data;
  logic [AW-2:0] px_addr;
  logic          px_valid;
  logic [1:0]    img_idx;
  logic          busy;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int ref_idx  = 0;

  always #5 clock = ~clock;

  assign fl_data = fl_addr[7:0];

  img_fetch_ctrl #(
    .FLASH_AW     (AW),
    .IMG_BYTES    (NB),
    .NUM_IMG      (NI),
    .FLASH_WAIT   (FW),
    .SLIDE_CYCLES (20)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_ready  (cmd_ready),
    .fl_addr    (fl_addr),
    .fl_oe      (fl_oe),
    .fl_data    (fl_data),
    .px_data    (px_data),
    .px_addr    (px_addr),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .img_idx    (img_idx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pixel w of image img: two consecutive flash bytes, low byte at the even address.
  function automatic logic [15:0] exp_pixel(input int img, input int w);
    int a;
    a = img * NB + 2 * w;
    return {8'(a + 1), 8'(a)};
  endfunction

  task automatic do_reset();
    @(posedge clock); #1;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    check_eq("rst_px_valid", px_valid, 0);
    check_eq("rst_fl_oe", fl_oe, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_img_idx", img_idx, 0);
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_px_data", px_data, 0);
    check_eq("rst_px_addr", px_addr, 0);
    @(posedge clock); #1;
    reset   = 1'b0;
    ref_idx = 0;
    @(negedge clock);
    check_eq("rst_setup_oe", fl_oe, 0);
    @(negedge clock);
    check_eq("rst_first_oe", fl_oe, 1);
    check_eq("rst_first_addr", fl_addr, 0);
  endtask

  task automatic send_cmd(input logic [1:0] code);
    @(posedge clock); #1;
    cmd_valid = 1'b1;
    cmd_code  = code;
    @(negedge clock);
    check_eq("cmd_ready_idle", cmd_ready, 1);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    case (code)
      CMD_NEXT:  ref_idx = (ref_idx + 1) % NI;
      CMD_PREV:  ref_idx = (ref_idx + NI - 1) % NI;
      CMD_FIRST: ref_idx = 0;
      default:   ;
    endcase
    @(negedge clock);
    check_eq("setup_oe", fl_oe, 0);
    check_eq("setup_busy", busy, 1);
    check_eq("cmd_img_idx", img_idx, ref_idx);
    @(negedge clock);
    check_eq("first_oe", fl_oe, 1);
    check_eq("first_addr", fl_addr, ref_idx * NB);
  endtask

  // mode 0: px_ready high; 1: random px_ready; 2: ten-cycle stall on the second pixel.
  task automatic run_frame(input int img, input int mode, input bit poke, input int stop_words);
    int   words = 0;
    int   cyc = 0;
    int   last_hs = -1;
    int   stalls = 0;
    int   stall_total = 0;
    bit   done = 1'b0;
    bit   after_hs = 1'b0;
    bit   prev_stall = 1'b0;
    logic [15:0]   held_data = '0;
    logic [AW-2:0] held_addr = '0;
    while (!done && cyc < 600 && (stop_words >= NW || words < stop_words)) begin
      @(posedge clock); #1;
      case (mode)
        0:       px_ready = 1'b1;
        1:       px_ready = ($urandom_range(0, 2) != 0);
        default: px_ready = !(words == 1 && stall_total < 10);
      endcase
      cmd_valid = poke && (words < NW) && ($urandom_range(0, 1) == 1);
      cmd_code  = 2'($urandom_range(0, 3));
      @(negedge clock);
      cyc++;
      if (prev_stall) begin
        check_eq("stall_valid", px_valid, 1);
        check_eq("stall_data", px_data, held_data);
        check_eq("stall_addr", px_addr, held_addr);
      end
      if (after_hs) begin
        check_eq("next_rd_oe", fl_oe, 1);
        check_eq("next_rd_addr", fl_addr, img * NB + 2 * words);
      end
      prev_stall = 1'b0;
      after_hs   = 1'b0;
      if (poke && words < NW) begin
        check_eq("busy_cmd_ready", cmd_ready, 0);
        check_eq("busy_img_idx", img_idx, img);
      end
      if (frame_done) begin
        done = 1'b1;
        check_eq("done_words", words, NW);
        check_eq("done_latency", cyc - last_hs, 1);
        check_eq("done_busy", busy, 0);
        check_eq("done_cmd_ready", cmd_ready, 1);
        check_eq("done_img_idx", img_idx, img);
      end else if (px_valid) begin
        if (px_ready) begin
          check_eq("px_data", px_data, exp_pixel(img, words));
          check_eq("px_addr", px_addr, words);
          if (last_hs >= 0) check_eq("word_cycles", cyc - last_hs, WORD_CYC + stalls);
          last_hs  = cyc;
          stalls   = 0;
          words++;
          after_hs = (words < NW);
        end else begin
          check_eq("stall_oe", fl_oe, 0);
          stalls++;
          stall_total++;
          prev_stall = 1'b1;
          held_data  = px_data;
          held_addr  = px_addr;
        end
      end
    end
    cmd_valid = 1'b0;
    px_ready  = 1'b1;
    if (stop_words >= NW) begin
      check_eq("frame_done_seen", done, 1);
      if (mode == 2) check_eq("stall_cycles", stall_total, 10);
      if (done) begin
        @(negedge clock);
        check_eq("done_pulse_once", frame_done, 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] code;
    do_reset();
    run_frame(0, 0, 0, NW);

    for (int i = 0; i < 3; i++) begin
      send_cmd(CMD_NEXT);
      run_frame(ref_idx, 0, 0, NW);
    end
    send_cmd(CMD_NEXT);
    run_frame(ref_idx, 0, 0, NW);
    send_cmd(CMD_PREV);
    run_frame(ref_idx, 0, 1, NW);

    send_cmd(CMD_RELOAD);
    run_frame(ref_idx, 2, 0, NW);

    for (int i = 0; i < 8; i++) begin
      code = 2'($urandom_range(0, 3));
      send_cmd(code);
      run_frame(ref_idx, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NW);
    end

    send_cmd(CMD_FIRST);
    run_frame(ref_idx, 0, 0, NW);
    send_cmd(CMD_NEXT);
    run_frame(ref_idx, 0, 0, NW);
    send_cmd(CMD_NEXT);
    run_frame(ref_idx, 0, 0, 2);
    do_reset();
    run_frame(0, 1, 0, NW);

`ifdef IMG_SLIDESHOW_EN
    // Idle cycle 1 is the frame_done cycle; the timer fires in idle cycle 20.
    for (int k = 3; k <= 20; k++) begin
      @(negedge clock);
      check_eq("slide_wait", busy, 0);
    end
    @(negedge clock);
    ref_idx = (ref_idx + 1) % NI;
    check_eq("slide_fire", busy, 1);
    check_eq("slide_img_idx", img_idx, ref_idx);
    run_frame(ref_idx, 0, 0, NW);
    for (int k = 3; k <= 14; k++) @(negedge clock);
    send_cmd(CMD_FIRST);
    run_frame(ref_idx, 0, 0, NW);
    for (int k = 3; k <= 20; k++) begin
      @(negedge clock);
      check_eq("slide_wait2", busy, 0);
    end
    @(negedge clock);
    ref_idx = (ref_idx + 1) % NI;
    check_eq("slide_fire2", busy, 1);
    check_eq("slide_img_idx2", img_idx, ref_idx);
    run_frame(ref_idx, 0, 0, NW);
`endif

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
